// File: rtl/fdiv_arb_if.sv
// fdiv_arb_if
//   Bundles the requester handshake, the fdiv operand/result bus and the
//   response handshake of fdiv_arb.
//   slave  : arbiter side (fdiv_arb)
//   master : environment side (requesters, fdiv unit, response consumer)
//   Signals:
//     req_valid/req_ready  per-requester operand handshake (NREQ bits)
//     req_x1/req_x2        packed operands, requester i at [32i+31:32i]
//     div_x1/div_x2        operands to fdiv, div_y result from fdiv
//     rsp_valid/rsp_ready  response handshake, rsp_y quotient, rsp_id source
interface fdiv_arb_if #(
    parameter int NREQ = 2
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_x1;
    logic [32*NREQ-1:0] req_x2;
    logic [31:0]        div_x1;
    logic [31:0]        div_x2;
    logic [31:0]        div_y;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_y;
    logic [IDW-1:0]     rsp_id;

    modport slave (
        input  req_valid, req_x1, req_x2, div_y, rsp_ready,
        output req_ready, div_x1, div_x2, rsp_valid, rsp_y, rsp_id
    );

    modport master (
        output req_valid, req_x1, req_x2, div_y, rsp_ready,
        input  req_ready, div_x1, div_x2, rsp_valid, rsp_y, rsp_id
    );
endinterface

// File: rtl/fdiv_arb.sv
// fdiv_arb
//   Shares one fixed-latency pipelined fdiv unit between NREQ requesters.
//   Round-robin front end issues at most one op per clock; a LAT-deep
//   valid/id shift register tracks ops in flight and lands each result in a
//   FIFO_DEPTH-entry result FIFO. A credit counter (in flight + FIFO
//   occupancy) stops issue before a landing result could find the FIFO full,
//   since fdiv itself cannot stall.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     bus          fdiv_arb_if.slave (requesters, fdiv bus, responses)
//   Optional: define FDIV_ARB_STATS_EN to add stat_issued / stat_stall
//   32-bit wrapping counters (issues, and cycles blocked by credit).
module fdiv_arb #(
    parameter int NREQ       = 2,
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    fdiv_arb_if.slave   bus
`ifdef FDIV_ARB_STATS_EN
    ,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_stall
`endif
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    logic [IDW-1:0] ptr_q, ptr_d, gnt;
    logic           found, can_issue, issue;
    int unsigned    arb_idx;
    logic [CW-1:0]  cred_q, cred_d;
    logic [LAT-1:0] v_q;
    logic [IDW-1:0] id_q [LAT];
    logic [31:0]    y_mem  [FIFO_DEPTH];
    logic [IDW-1:0] id_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           push, pop, rsp_valid;

    // Registered credit only: a pop in this cycle frees its credit next cycle.
    assign can_issue = (cred_q < CRED_MAX);

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        arb_idx = 0;
        found   = 1'b0;
        gnt     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            arb_idx = (32'(ptr_q) + k) % unsigned'(NREQ);
            if (!found && bus.req_valid[IDW'(arb_idx)]) begin
                found = 1'b1;
                gnt   = IDW'(arb_idx);
            end
        end
    end

    assign issue = found && can_issue && !rst;
    assign ptr_d = issue ? gnt : ptr_q;

    always_comb begin
        bus.req_ready = '0;
        bus.div_x1    = '0;
        bus.div_x2    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (issue && gnt == IDW'(i)) begin
                bus.req_ready[i] = 1'b1;
                bus.div_x1       = bus.req_x1[32*i +: 32];
                bus.div_x2       = bus.req_x2[32*i +: 32];
            end
        end
    end

    // Last shift stage valid means div_y carries that op's quotient now.
    assign push      = v_q[LAT-1];
    assign rsp_valid = (cnt_q != '0) && !rst;
    assign pop       = rsp_valid && bus.rsp_ready;

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_y     = y_mem[rd_q];
    assign bus.rsp_id    = id_mem[rd_q];

    always_comb begin
        cred_d = cred_q;
        if (issue && !pop) begin
            cred_d = cred_q + 1'b1;
        end else if (!issue && pop) begin
            cred_d = cred_q - 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        wr_d = wr_q;
        if (push) begin
            wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
        end
        rd_d = rd_q;
        if (pop) begin
            rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= IDW'(NREQ - 1);
            cred_q <= '0;
            cnt_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            v_q    <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cred_q <= cred_d;
            cnt_q  <= cnt_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            v_q[0] <= issue;
            for (int unsigned i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
            end
        end
    end

    // Datapath storage needs no reset; validity lives in v_q and cnt_q.
    always_ff @(posedge clk) begin
        id_q[0] <= gnt;
        for (int unsigned i = 1; i < LAT; i++) begin
            id_q[i] <= id_q[i-1];
        end
        if (push) begin
            y_mem[wr_q]  <= bus.div_y;
            id_mem[wr_q] <= id_q[LAT-1];
        end
    end

    full_on_push: assert property (@(posedge clk) disable iff (rst)
        !(push && cnt_q == CRED_MAX));

`ifdef FDIV_ARB_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (issue) begin
                stat_issued_q <= stat_issued_q + 32'd1;
            end
            if (|bus.req_valid && !can_issue) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif
endmodule

// File: tb/tb_fdiv_arb.sv
// tb_fdiv_arb
//   Directed bench for fdiv_arb (NREQ=2, LAT=4, FIFO_DEPTH=4) with a
//   table-driven fdiv stand-in and a queue model of issued ops checked
//   every cycle at the falling edge.
module tb_fdiv_arb;
    localparam int NREQ = 2;
    localparam int LAT  = 4;
    localparam int FD   = 4;
    localparam int IDW  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fdiv_arb_if #(.NREQ(NREQ)) bus ();
`ifdef FDIV_ARB_STATS_EN
    logic [31:0] stat_issued, stat_stall;
`endif

    fdiv_arb #(.NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef FDIV_ARB_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    logic [31:0] x1a [NREQ];
    logic [31:0] x2a [NREQ];
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x1[32*i +: 32] = x1a[i];
            bus.req_x2[32*i +: 32] = x2a[i];
        end
    end

    function automatic logic [31:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40400000, 32'h40000000}: return 32'h3FC00000;
            {32'h437F0000, 32'hC37F0000}: return 32'hBF800000;
            {32'h40200000, 32'h40000000}: return 32'h3FA00000;
            {32'h3F800000, 32'h40000000}: return 32'h3F000000;
            {32'h3F800000, 32'h3F8CCCCD}: return 32'h3F68BA2E;
            default:                      return 32'h00000000;
        endcase
    endfunction

    // fdiv stand-in: operands sampled at an edge, quotient on y LAT-1 edges later.
    logic [31:0] fpipe [LAT];
    always @(posedge clk) begin
        fpipe[0] <= fdiv_ref(bus.div_x1, bus.div_x2);
        for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
    end
    assign bus.div_y = fpipe[LAT-1];

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Model: every issued op waits in one ordered queue until consumed.
    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    y;
        int             avail;
    } rsp_t;
    rsp_t           mq [$];
    int unsigned    mptr = NREQ - 1;
    int             cyc  = 0;
    logic           mgf, exp_v;
    logic [IDW-1:0] mgi, mcand;
    logic [NREQ-1:0] exp_rdy;
    logic [31:0]    ex1, ex2;

    always @(negedge clk) begin
        mgf = 1'b0;
        mgi = '0;
        if (!rst && mq.size() < FD) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                mcand = IDW'((mptr + k) % NREQ);
                if (!mgf && bus.req_valid[mcand]) begin
                    mgf = 1'b1;
                    mgi = mcand;
                end
            end
        end
        exp_rdy = '0;
        ex1     = '0;
        ex2     = '0;
        if (mgf) begin
            exp_rdy[mgi] = 1'b1;
            ex1          = x1a[mgi];
            ex2          = x2a[mgi];
        end
        exp_v = !rst && mq.size() > 0 && mq[0].avail <= cyc;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("div_x1", bus.div_x1, ex1);
        check("div_x2", bus.div_x2, ex2);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
        if (exp_v) begin
            check("rsp_y", bus.rsp_y, mq[0].y);
            check("rsp_id", 32'(bus.rsp_id), 32'(mq[0].id));
        end
        if (rst) begin
            mq.delete();
            mptr = NREQ - 1;
        end else begin
            if (exp_v && bus.rsp_ready) void'(mq.pop_front());
            if (mgf) begin
                mq.push_back('{id: mgi, y: fdiv_ref(ex1, ex2), avail: cyc + LAT + 1});
                mptr = 32'(mgi);
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [NREQ-1:0] grants [$];
    logic [32:0]     rsps   [$];
    logic            last_rdy;
    logic [31:0]     pat = 32'hF7BF_EFFF;
    int lat, nis, ndr, bad, niss, nrsp, nval;

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            x1a[i] = '0;
            x2a[i] = '0;
        end
        @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'h0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        step();
        step();
        rst = 1'b0;

        // Single op
        x1a[0] = 32'h40400000; x2a[0] = 32'h40000000;
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("t1_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) lat = k;
        end
        check("t1_latency", 32'(lat), 32'(LAT + 1));
        check("t1_y", bus.rsp_y, 32'h3FC00000);
        check("t1_id", 32'(bus.rsp_id), 32'h0);

        // Round robin
        step();
        do_reset();
        x1a[0] = 32'h437F0000; x2a[0] = 32'hC37F0000;
        x1a[1] = 32'h40200000; x2a[1] = 32'h40000000;
        bus.req_valid = 2'b11;
        grants.delete();
        for (int k = 0; k < 30 && grants.size() < 4; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) grants.push_back(bus.req_ready);
            step();
        end
        bus.req_valid = '0;
        check("t2_ngrants", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("t2_grant", 32'(grants[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        rsps.delete();
        for (int k = 0; k < 40 && rsps.size() < 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) rsps.push_back({bus.rsp_id, bus.rsp_y});
        end
        check("t2_nrsp", 32'(rsps.size()), 32'd4);
        for (int i = 0; i < 4 && i < rsps.size(); i++)
            check("t2_rsp", rsps[i][31:0], (i % 2 == 0) ? 32'hBF800000 : 32'h3FA00000);
        for (int i = 0; i < 4 && i < rsps.size(); i++)
            check("t2_rsp_id", 32'(rsps[i][32]), 32'(i % 2));

        // Backpressure
        step();
        do_reset();
        bus.rsp_ready = 1'b0;
        x1a[0] = 32'h3F800000; x2a[0] = 32'h40000000;
        bus.req_valid = 2'b01;
        nis = 0;
        last_rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.req_ready[0]) nis++;
            last_rdy = bus.req_ready[0];
            step();
        end
        bus.req_valid = '0;
        check("t3_issues", 32'(nis), 32'd4);
        check("t3_blocked", 32'(last_rdy), 32'h0);
        @(negedge clk);
`ifdef FDIV_ARB_STATS_EN
        check("t3_stat_issued", stat_issued, 32'd4);
        check("t3_stat_stall", stat_stall, 32'd8);
`endif
        step();
        bus.rsp_ready = 1'b1;
        ndr = 0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ndr++;
                if (bus.rsp_y != 32'h3F000000) bad++;
            end
            step();
        end
        check("t3_drained", 32'(ndr), 32'd4);
        check("t3_drain_vals", 32'(bad), 32'd0);
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("t3_resume", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        repeat (8) step();

        // Pointer wrap with full credit and mixed backpressure
        do_reset();
        @(negedge clk);
`ifdef FDIV_ARB_STATS_EN
        check("t4_stat_issued_rst", stat_issued, 32'd0);
        check("t4_stat_stall_rst", stat_stall, 32'd0);
`endif
        step();
        x1a[0] = 32'h3F800000; x2a[0] = 32'h40000000;
        x1a[1] = 32'h40400000; x2a[1] = 32'h40000000;
        bus.req_valid = 2'b11;
        niss = 0;
        nrsp = 0;
        bad  = 0;
        for (int k = 0; k < 60; k++) begin
            if (k == 40) bus.req_valid = '0;
            bus.rsp_ready = (k < 40) ? pat[k[4:0]] : 1'b1;
            @(negedge clk);
            if (bus.req_ready != '0) niss++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (32'(bus.rsp_id) != 32'(nrsp % 2)) bad++;
                if (bus.rsp_y != ((nrsp % 2 == 0) ? 32'h3F000000 : 32'h3FC00000)) bad++;
                nrsp++;
            end
            step();
        end
        check("t4_rsp_count", 32'(nrsp), 32'(niss));
        check("t4_enough", 32'(niss >= 12), 32'h1);
        check("t4_order", 32'(bad), 32'd0);

        // Reset mid-operation
        do_reset();
        bus.rsp_ready = 1'b1;
        x1a[0] = 32'h3F800000; x2a[0] = 32'h40000000;
        bus.req_valid = 2'b01;
        step();
        step();
        step();
        bus.req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        nval = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) nval++;
            step();
        end
        check("t5_discarded", 32'(nval), 32'd0);
        x1a[0] = 32'h3F800000; x2a[0] = 32'h3F8CCCCD;
        x1a[1] = 32'h40200000; x2a[1] = 32'h40000000;
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("t5_first_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) lat = k;
        end
        check("t5_latency", 32'(lat), 32'(LAT + 1));
        check("t5_y", bus.rsp_y, 32'h3F68BA2E);
        check("t5_id", 32'(bus.rsp_id), 32'h0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fdiv_arb.md
Name: fdiv_arb

Overview:
- Shares one fixed-latency pipelined fdiv unit between NREQ requesters.
- Front end: round-robin arbitration with valid/ready handshakes, drives fdiv x1/x2.
- Back end: tracks in-flight ops with a valid/id shift register and captures fdiv y into a result FIFO with downstream backpressure.
- A credit counter guarantees no result is dropped, even though fdiv cannot stall.

Parameters:
- NREQ, 2, number of requesters (≥1); IDW = max(1, $clog2(NREQ)).
- LAT, 4, fdiv latency in clocks, operands sampled at edge t to y valid during cycle t+LAT (≥1).
- FIFO_DEPTH, 4, result FIFO entries and total credit limit (≥1; LAT+1 needed for full throughput).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_x1  in  32*NREQ  dividend, requester i at [32i+31:32i]
- req_x2  in  32*NREQ  divisor, same packing
- div_x1  out  32  to fdiv x1
- div_x2  out  32  to fdiv x2
- div_y  in  32  from fdiv y
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accept
- rsp_y  out  32  quotient
- rsp_id  out  IDW  index of issuing requester

Behaviour:
- Reset (rst=1 at edge) clears the following:
  - rsp_valid=0 and req_ready=0 during reset.
  - The in-flight shift register, FIFO pointers/count and credit count are cleared to 0.
  - RR pointer is set to NREQ-1, so requester 0 has top priority first.
  - Results of ops in flight at reset are discarded; fdiv needs no reset.
- Credit: count = in-flight + FIFO occupancy.
  - +1 on issue, −1 on rsp handshake; both in the same cycle leaves it unchanged.
  - can_issue = (count < FIFO_DEPTH), using the registered count only, with no same-cycle pop bypass.
- Arbitration (combinational):
  - Search starts at ptr+1 mod NREQ; the first i with req_valid[i] wins.
  - req_ready[g] = can_issue && !rst; every other req_ready is 0.
  - Issue = req_valid[g] && req_ready[g]; ptr←g on issue only.
  - req_ready depends on req_valid (documented; requesters must not wait on ready before asserting valid).
- div_x1/div_x2 = req_x1/req_x2 of the granted requester when issuing, else 32'h0.
- Pipeline tracking:
  - The LAT-stage shift register {v,id} shifts every clock; stage0 ← {issue, g}.
  - When stage LAT−1 is valid, div_y is the result for that id in the current cycle and is pushed into the FIFO at that edge.
  - Credits guarantee the FIFO is never full on push; an assertion flags any violation.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - Simultaneous push and pop is allowed at any occupancy, including empty with no bypass.
  - rsp_valid = !empty; rsp_y/rsp_id come from the head entry and are stable while rsp_valid && !rsp_ready.
- Latency: issue at edge t → rsp_valid at earliest in cycle t+LAT+1.
- Results return in issue order; back-to-back issue at 1 op/clk when FIFO_DEPTH ≥ LAT+1 and rsp_ready=1.

Optional Feature:
- Macro FDIV_ARB_STATS_EN.
- Defined:
  - Adds output ports stat_issued (32) and stat_stall (32), both reset to 0.
  - stat_issued increments per issue.
  - stat_stall increments each cycle where any req_valid=1, can_issue=0 and rst=0.
  - Both counters wrap modulo 2^32.
- Undefined: no ports, no counters, and identical behaviour otherwise.

Test Plan:
- Single op: NREQ=2, LAT=4, requester 0 sends x1=0x40400000, x2=0x40000000 with rsp_ready=1. Expect req_ready[0]=1 at issue, rsp_valid exactly LAT+1 cycles later, rsp_y=0x3FC00000 (1.5), rsp_id=0.
- Round robin: both requesters hold valid continuously, r0=0x437F0000/0xC37F0000 and r1=0x40200000/0x40000000. Expect grants to alternate 0,1,0,1 and responses 0xBF800000 (id0) and 0x3FA00000 (id1) interleaved in order.
- Backpressure: FIFO_DEPTH=4, rsp_ready=0, r0 valid continuously (x1=0x3F800000, x2=0x40000000). Expect exactly 4 issues then req_ready=0 and no further issue. Raising rsp_ready then drains 4× 0x3F000000 and issue resumes, with no lost or duplicated results.
- Simultaneous push/pop at full credit: count=FIFO_DEPTH, then pop and landing result in the same cycle. Expect count unchanged, FIFO not overflowed, and ordering preserved across pointer wrap after ≥3 full cycles.
- Reset mid-operation: issue 3 ops, assert rst for 1 cycle two cycles later. Expect rsp_valid=0 permanently for those ops, credit count 0, requester 0 granted first afterwards, and a fresh op 0x3F800000/0x3F8CCCCD returning 0x3F68BA2E.
- FDIV_ARB_STATS_EN: run the backpressure scenario. Expect stat_issued=4 before drain, stat_stall equal to the number of blocked valid cycles, and both counters 0 after rst.
